mdio_master: RTL and testbench

Parametrised Clause-22 MDIO management master, successor to the fixed-rate PHY register accessor.
- MDC is derived internally from the system clock through a programmable divider.
- PHY address is taken per transaction, and preamble suppression is optional.
- A turnaround error flag is reported on reads, and a single-cycle completion pulse is issued.
- Sits between the Ethernet control FSM and the PHY management pins. The top level instantiates the tristate buffer from mdio_out/mdio_oe/mdio_in.

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_clk_gen.sv | 40 ++++
 rtl/mdio_master.sv | 190 +++++++++++++++++++
 tb/tb_mdio_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, field widths, state encoding and header layout for the MDIO master.
package mdio_pkg;

    localparam int unsigned PHYAD_W  = 5;
    localparam int unsigned REGAD_W  = 5;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned HDR_W    = 14;
    localparam int unsigned TA_W     = 2;
    localparam int unsigned BITCNT_W = 6;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        TA,
        DATA,
        END
    } mdio_state_e;

    // ST + OP + PHYAD + REGAD, shifted out MSB first
    typedef struct packed {
        logic [1:0]         st;
        logic [1:0]         op;
        logic [PHYAD_W-1:0] phyad;
        logic [REGAD_W-1:0] regad;
    } mdio_hdr_t;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: half-period tick counter, free-running only while enabled.
module mdio_clk_gen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_en,
    output logic o_mdc,
    output logic o_rise_c,
    output logic o_period_end_c
);

    localparam int unsigned TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

    logic [TICK_W-1:0] r_tick;
    logic              r_half;
    logic              w_tick;

    assign w_tick         = i_en && (r_tick == TICK_LAST);
    assign o_rise_c       = w_tick && !r_half;
    assign o_period_end_c = w_tick && r_half;
    assign o_mdc          = r_half;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= '0;
            r_half <= 1'b0;
        end else if (!i_en) begin
            r_tick <= '0;
            r_half <= 1'b0;
        end else if (w_tick) begin
            r_tick <= '0;
            r_half <= ~r_half;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: frames one read or write per request on mdc/mdio.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 10,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [PHYAD_W-1:0] phy_addr,
    input  logic [REGAD_W-1:0] reg_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               rd_request,
    input  logic               wr_request,
    input  logic               no_preamble,
    output logic               ready,
    output logic               done,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_error,
    output logic               mdc,
    output logic               mdio_out,
    output logic               mdio_oe,
    input  logic               mdio_in
);

    if (CLK_DIV == 0) begin : g_bad_clk_div
        $error("mdio_master: CLK_DIV must be at least 1");
    end
    if ((PREAMBLE_BITS == 0) || (PREAMBLE_BITS > 32)) begin : g_bad_preamble
        $error("mdio_master: PREAMBLE_BITS must be in 1..32");
    end

    mdio_state_e         r_state;
    logic [BITCNT_W-1:0] r_bit_cnt;
    logic                r_is_rd;
    logic [HDR_W-1:0]    r_hdr;
    logic [DATA_W-1:0]   r_wd;
    logic [DATA_W-1:0]   r_rdsh;
    logic                r_ta_err;
    logic                r_ready;
    logic                r_done;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_error;
    logic                r_mdio_out;
    logic                r_mdio_oe;

    logic      w_en;
    logic      w_rise;
    logic      w_pend;
    logic      w_mdc;
    logic      w_req;
    mdio_hdr_t w_hdr;

    assign w_en  = (r_state != IDLE);
    assign w_req = rd_request || wr_request;
    assign w_hdr = '{st: MDIO_ST, op: (rd_request ? MDIO_OP_RD : MDIO_OP_WR),
                     phyad: phy_addr, regad: reg_addr};

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_en           (w_en),
        .o_mdc          (w_mdc),
        .o_rise_c       (w_rise),
        .o_period_end_c (w_pend)
    );

    // Line values change on period_end so each bit is set up on the first clock of its period
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_is_rd    <= 1'b0;
            r_hdr      <= '0;
            r_wd       <= '0;
            r_rdsh     <= '0;
            r_ta_err   <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_error <= 1'b0;
            r_mdio_out <= 1'b1;
            r_mdio_oe  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_rise && r_is_rd) begin
                if ((r_state == TA) && (r_bit_cnt == '0)) r_ta_err <= mdio_in;
                if (r_state == DATA) r_rdsh <= {r_rdsh[DATA_W-2:0], mdio_in};
            end

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_ready   <= 1'b0;
                        r_is_rd   <= rd_request;
                        r_wd      <= wr_data;
                        r_mdio_oe <= 1'b1;
                        if (no_preamble) begin
                            r_state    <= HEADER;
                            r_bit_cnt  <= BITCNT_W'(HDR_W - 1);
                            r_mdio_out <= w_hdr[HDR_W-1];
                            r_hdr      <= {w_hdr[HDR_W-2:0], 1'b0};
                        end else begin
                            r_state    <= PREAMBLE;
                            r_bit_cnt  <= BITCNT_W'(PREAMBLE_BITS - 1);
                            r_mdio_out <= 1'b1;
                            r_hdr      <= w_hdr;
                        end
                    end
                end
                PREAMBLE: begin
                    if (w_pend) begin
                        if (r_bit_cnt == '0) begin
                            r_state    <= HEADER;
                            r_bit_cnt  <= BITCNT_W'(HDR_W - 1);
                            r_mdio_out <= r_hdr[HDR_W-1];
                            r_hdr      <= {r_hdr[HDR_W-2:0], 1'b0};
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (w_pend) begin
                        if (r_bit_cnt == '0) begin
                            r_state    <= TA;
                            r_bit_cnt  <= BITCNT_W'(TA_W - 1);
                            r_mdio_out <= r_is_rd ? 1'b1 : MDIO_TA_WR[1];
                            r_mdio_oe  <= !r_is_rd;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt - 1'b1;
                            r_mdio_out <= r_hdr[HDR_W-1];
                            r_hdr      <= {r_hdr[HDR_W-2:0], 1'b0};
                        end
                    end
                end
                TA: begin
                    if (w_pend) begin
                        if (r_bit_cnt == '0) begin
                            r_state    <= DATA;
                            r_bit_cnt  <= BITCNT_W'(DATA_W - 1);
                            r_mdio_out <= r_is_rd ? 1'b1 : r_wd[DATA_W-1];
                            r_wd       <= {r_wd[DATA_W-2:0], 1'b0};
                        end else begin
                            r_bit_cnt  <= r_bit_cnt - 1'b1;
                            r_mdio_out <= r_is_rd ? 1'b1 : MDIO_TA_WR[0];
                        end
                    end
                end
                DATA: begin
                    if (w_pend) begin
                        if (r_bit_cnt == '0) begin
                            r_state    <= END;
                            r_mdio_out <= 1'b1;
                            r_mdio_oe  <= 1'b0;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt - 1'b1;
                            r_mdio_out <= r_is_rd ? 1'b1 : r_wd[DATA_W-1];
                            r_wd       <= {r_wd[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                END: begin
                    if (w_pend) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        if (r_is_rd) begin
                            r_rd_data  <= r_rdsh;
                            r_rd_error <= r_ta_err;
                        end else begin
                            r_rd_error <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign rd_error = r_rd_error;
    assign mdc      = w_mdc;
    assign mdio_out = r_mdio_out;
    assign mdio_oe  = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame content, latency, read status, reset and back-to-back timing.
`timescale 1ns/1ps
module tb_mdio_master;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [4:0]  phy_addr, reg_addr;
    logic [15:0] wr_data;
    logic        rd_request, wr_request, no_preamble, mdio_in;
    logic        ready, done, rd_error, mdc, mdio_out, mdio_oe;
    logic [15:0] rd_data;

    logic        wr1, ready1, done1, rderr1, mdc1, out1, oe1;
    logic [15:0] rdd1;
    logic        wr7, ready7, done7, rderr7, mdc7, out7, oe7;
    logic [15:0] rdd7;

    int n_checks = 0;
    int n_errors = 0;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .phy_addr(phy_addr), .reg_addr(reg_addr),
        .wr_data(wr_data), .rd_request(rd_request), .wr_request(wr_request),
        .no_preamble(no_preamble), .ready(ready), .done(done), .rd_data(rd_data),
        .rd_error(rd_error), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
        .mdio_in(mdio_in)
    );

    mdio_master #(.CLK_DIV(1), .PREAMBLE_BITS(32)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .phy_addr(5'h04), .reg_addr(5'h09),
        .wr_data(16'hBEEF), .rd_request(1'b0), .wr_request(wr1),
        .no_preamble(1'b1), .ready(ready1), .done(done1), .rd_data(rdd1),
        .rd_error(rderr1), .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1),
        .mdio_in(1'b1)
    );

    mdio_master #(.CLK_DIV(7), .PREAMBLE_BITS(32)) u_dut7 (
        .clock(clock), .reset_n(reset_n), .phy_addr(5'h04), .reg_addr(5'h09),
        .wr_data(16'hBEEF), .rd_request(1'b0), .wr_request(wr7),
        .no_preamble(1'b1), .ready(ready7), .done(done7), .rd_data(rdd7),
        .rd_error(rderr7), .mdc(mdc7), .mdio_out(out7), .mdio_oe(oe7),
        .mdio_in(1'b1)
    );

    // Line sampling at each mdc rise and edge timestamps, taken from pre-edge values
    int   cyc = 0;
    logic mdc_q, mdc1_q, mdc7_q;
    logic cap_out[$];
    logic cap_oe[$];
    int   rise1[$], rise7[$], done1_t[$], done7_t[$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mdc === 1'b1 && mdc_q === 1'b0) begin
            cap_out.push_back(mdio_out);
            cap_oe.push_back(mdio_oe);
        end
        if (mdc1 === 1'b1 && mdc1_q === 1'b0) rise1.push_back(cyc);
        if (mdc7 === 1'b1 && mdc7_q === 1'b0) rise7.push_back(cyc);
        if (done1 === 1'b1) done1_t.push_back(cyc);
        if (done7 === 1'b1) done7_t.push_back(cyc);
        mdc_q  <= mdc;
        mdc1_q <= mdc1;
        mdc7_q <= mdc7;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One request on the CLK_DIV=2 instance with a PHY model on mdio_in; returns clocks from acceptance to done
    task automatic do_txn(input logic rd, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic np, input logic ta2,
                          input logic [15:0] pdata, input bit pulse_wr,
                          output int lat, output bit rdy_ok);
        int p;
        int b;
        int idx;
        p      = np ? 0 : 32;
        lat    = -1;
        rdy_ok = 1'b1;
        phy_addr = pa; reg_addr = ra; wr_data = wd; no_preamble = np;
        rd_request = rd; wr_request = wr;
        tick();
        rd_request = 1'b0; wr_request = 1'b0;
        phy_addr = ~pa; reg_addr = ~ra; wr_data = ~wd; no_preamble = ~np;
        for (int e = 0; e < 3000; e++) begin
            if (e % 4 == 0) begin
                b = e / 4;
                if (b == p + 15) mdio_in = ta2;
                else if (b >= p + 16 && b < p + 32) begin
                    idx = 31 + p - b;
                    mdio_in = pdata[idx[3:0]];
                end else mdio_in = 1'b1;
            end
            if (pulse_wr) wr_request = (e == 20);
            if (done === 1'b1) begin
                lat = e;
                break;
            end
            if (ready !== 1'b0) rdy_ok = 1'b0;
            tick();
        end
        wr_request = 1'b0;
        mdio_in    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks += 7;
        if (ready !== 1'b1)       begin n_errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        if (done !== 1'b0)        begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (rd_data !== 16'h0000) begin n_errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        if (rd_error !== 1'b0)    begin n_errors++; $display("FAIL reset_rd_error: got %b want 0", rd_error); end
        if (mdc !== 1'b0)         begin n_errors++; $display("FAIL reset_mdc: got %b want 0", mdc); end
        if (mdio_out !== 1'b1)    begin n_errors++; $display("FAIL reset_mdio_out: got %b want 1", mdio_out); end
        if (mdio_oe !== 1'b0)     begin n_errors++; $display("FAIL reset_mdio_oe: got %b want 0", mdio_oe); end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write_preamble();
        logic [64:0] exp_bits, exp_oe, act_bits, act_oe;
        int lat;
        bit rdy_ok;
        exp_bits = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00000, 2'b10, 16'h1140, 1'b1};
        exp_oe   = {{64{1'b1}}, 1'b0};
        act_bits = 'x;
        act_oe   = 'x;
        cap_out.delete(); cap_oe.delete();
        do_txn(1'b0, 1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b1, 16'hFFFF, 1'b0, lat, rdy_ok);
        for (int i = 0; i < cap_out.size() && i < 65; i++) begin
            act_bits[64-i] = cap_out[i];
            act_oe[64-i]   = cap_oe[i];
        end
        n_checks += 6;
        if (lat !== 260) begin n_errors++; $display("FAIL wr_latency: got %0d want 260", lat); end
        if (!rdy_ok) begin n_errors++; $display("FAIL wr_ready_busy: ready not 0 over k+1..k+260"); end
        if (ready !== 1'b1) begin n_errors++; $display("FAIL wr_ready_done: got %b want 1", ready); end
        if (cap_out.size() != 65) begin n_errors++; $display("FAIL wr_bit_count: got %0d want 65", cap_out.size()); end
        if (act_bits !== exp_bits) begin n_errors++; $display("FAIL wr_frame_bits: got %h want %h", act_bits, exp_bits); end
        if (act_oe !== exp_oe) begin n_errors++; $display("FAIL wr_frame_oe: got %h want %h", act_oe, exp_oe); end
        tick();
        n_checks += 3;
        if (done !== 1'b0) begin n_errors++; $display("FAIL wr_done_pulse: got %b want 0", done); end
        if (mdc !== 1'b0 || mdio_oe !== 1'b0 || mdio_out !== 1'b1) begin
            n_errors++; $display("FAIL wr_idle_lines: got mdc=%b oe=%b out=%b want 0 0 1", mdc, mdio_oe, mdio_out);
        end
        if (rd_error !== 1'b0) begin n_errors++; $display("FAIL wr_rd_error: got %b want 0", rd_error); end
    endtask

    task automatic test_read();
        logic [32:0] exp_oe, act_oe;
        logic [13:0] exp_hdr, act_hdr;
        int lat;
        bit rdy_ok;
        exp_oe  = {{14{1'b1}}, {19{1'b0}}};
        exp_hdr = {2'b01, 2'b10, 5'b00011, 5'b00010};
        act_oe  = 'x;
        act_hdr = 'x;
        cap_out.delete(); cap_oe.delete();
        do_txn(1'b1, 1'b0, 5'h03, 5'h02, 16'h0000, 1'b1, 1'b0, 16'h0022, 1'b0, lat, rdy_ok);
        for (int i = 0; i < cap_oe.size() && i < 33; i++) act_oe[32-i] = cap_oe[i];
        for (int i = 0; i < cap_out.size() && i < 14; i++) act_hdr[13-i] = cap_out[i];
        n_checks += 6;
        if (lat !== 132) begin n_errors++; $display("FAIL rd_latency: got %0d want 132", lat); end
        if (!rdy_ok) begin n_errors++; $display("FAIL rd_ready_busy: ready not 0 while busy"); end
        if (rd_data !== 16'h0022) begin n_errors++; $display("FAIL rd_data: got %h want 0022", rd_data); end
        if (rd_error !== 1'b0) begin n_errors++; $display("FAIL rd_error_ok: got %b want 0", rd_error); end
        if (act_oe !== exp_oe) begin n_errors++; $display("FAIL rd_frame_oe: got %h want %h", act_oe, exp_oe); end
        if (act_hdr !== exp_hdr) begin n_errors++; $display("FAIL rd_header: got %b want %b", act_hdr, exp_hdr); end
        tick();
    endtask

    task automatic test_read_error();
        int lat;
        bit rdy_ok;
        do_txn(1'b1, 1'b0, 5'h03, 5'h02, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, lat, rdy_ok);
        n_checks += 2;
        if (rd_error !== 1'b1) begin n_errors++; $display("FAIL rderr_flag: got %b want 1", rd_error); end
        if (rd_data !== 16'hFFFF) begin n_errors++; $display("FAIL rderr_data: got %h want ffff", rd_data); end
        tick();
        do_txn(1'b0, 1'b1, 5'h03, 5'h02, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, lat, rdy_ok);
        n_checks += 3;
        if (lat !== 132) begin n_errors++; $display("FAIL wr_np_latency: got %0d want 132", lat); end
        if (rd_error !== 1'b0) begin n_errors++; $display("FAIL wr_clears_rderr: got %b want 0", rd_error); end
        if (rd_data !== 16'hFFFF) begin n_errors++; $display("FAIL wr_keeps_rd_data: got %h want ffff", rd_data); end
        tick();
    endtask

    task automatic test_collision();
        int lat;
        bit rdy_ok;
        cap_out.delete(); cap_oe.delete();
        do_txn(1'b1, 1'b1, 5'h0A, 5'h11, 16'h5555, 1'b1, 1'b0, 16'hA5C3, 1'b1, lat, rdy_ok);
        n_checks += 3;
        if (lat !== 132) begin n_errors++; $display("FAIL coll_latency: got %0d want 132", lat); end
        if (cap_out.size() < 4 || cap_out[2] !== 1'b1 || cap_out[3] !== 1'b0) begin
            n_errors++; $display("FAIL coll_opcode: captured %0d bits, OP not 10", cap_out.size());
        end
        if (rd_data !== 16'hA5C3) begin n_errors++; $display("FAIL coll_rd_data: got %h want a5c3", rd_data); end
        repeat (40) tick();
        n_checks += 2;
        if (cap_out.size() != 33) begin n_errors++; $display("FAIL coll_no_second_frame: got %0d bits want 33", cap_out.size()); end
        if (ready !== 1'b1 || mdc !== 1'b0) begin
            n_errors++; $display("FAIL coll_idle_after: got ready=%b mdc=%b want 1 0", ready, mdc);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit rdy_ok;
        phy_addr = 5'h07; reg_addr = 5'h04; wr_data = 16'hFFFF; no_preamble = 1'b0;
        wr_request = 1'b1;
        tick();
        wr_request = 1'b0;
        repeat (50 * 4 + 1) tick();
        n_checks += 1;
        if (mdio_oe !== 1'b1 || ready !== 1'b0) begin
            n_errors++; $display("FAIL mid_pre_state: got oe=%b ready=%b want 1 0", mdio_oe, ready);
        end
        reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (mdc !== 1'b0)     begin n_errors++; $display("FAIL mid_rst_mdc: got %b want 0", mdc); end
        if (mdio_oe !== 1'b0) begin n_errors++; $display("FAIL mid_rst_oe: got %b want 0", mdio_oe); end
        if (ready !== 1'b1)   begin n_errors++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
        if (done !== 1'b0)    begin n_errors++; $display("FAIL mid_rst_done: got %b want 0", done); end
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        do_txn(1'b1, 1'b0, 5'h03, 5'h02, 16'h0000, 1'b1, 1'b0, 16'h1357, 1'b0, lat, rdy_ok);
        n_checks += 3;
        if (lat !== 132) begin n_errors++; $display("FAIL post_rst_latency: got %0d want 132", lat); end
        if (rd_data !== 16'h1357) begin n_errors++; $display("FAIL post_rst_rd_data: got %h want 1357", rd_data); end
        if (rd_error !== 1'b0) begin n_errors++; $display("FAIL post_rst_rd_error: got %b want 0", rd_error); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n1, n7, d, bad, gap;
        int rq[$];
        int dq[$];
        n1 = 0; n7 = 0;
        rise1.delete(); rise7.delete(); done1_t.delete(); done7_t.delete();
        wr1 = 1'b1; wr7 = 1'b1;
        tick();
        for (int e = 0; e < 3000 && (n1 < 2 || n7 < 2); e++) begin
            if (done1 === 1'b1) n1++;
            else if (n1 >= 1) wr1 = 1'b0;
            if (done7 === 1'b1) n7++;
            else if (n7 >= 1) wr7 = 1'b0;
            tick();
        end
        wr1 = 1'b0; wr7 = 1'b0;
        repeat (5) tick();
        for (int u = 0; u < 2; u++) begin
            if (u == 0) begin d = 1; rq = rise1; dq = done1_t; end
            else        begin d = 7; rq = rise7; dq = done7_t; end
            bad = 0;
            gap = -1;
            for (int i = 1; i < rq.size(); i++) begin
                if (i == 33) gap = rq[i] - rq[i-1];
                else if (rq[i] - rq[i-1] != 2 * d) bad++;
            end
            n_checks += 4;
            if (rq.size() != 66) begin n_errors++; $display("FAIL b2b_rises_div%0d: got %0d want 66", d, rq.size()); end
            if (bad != 0) begin n_errors++; $display("FAIL b2b_mdc_period_div%0d: %0d periods not %0d clocks", d, bad, 2 * d); end
            if (gap != 2 * d + 1) begin n_errors++; $display("FAIL b2b_frame_gap_div%0d: got %0d want %0d", d, gap, 2 * d + 1); end
            if (dq.size() != 2 || dq[1] - dq[0] != 66 * d + 1) begin
                n_errors++; $display("FAIL b2b_done_spacing_div%0d: got %0d pulses want 2 at spacing %0d", d, dq.size(), 66 * d + 1);
            end
        end
        n_checks += 1;
        if (ready1 !== 1'b1 || ready7 !== 1'b1 || mdc1 !== 1'b0 || mdc7 !== 1'b0) begin
            n_errors++; $display("FAIL b2b_idle: got ready1=%b ready7=%b mdc1=%b mdc7=%b", ready1, ready7, mdc1, mdc7);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        phy_addr = '0; reg_addr = '0; wr_data = '0;
        rd_request = 1'b0; wr_request = 1'b0; no_preamble = 1'b0; mdio_in = 1'b1;
        wr1 = 1'b0; wr7 = 1'b0;
        #1;
        test_reset();
        test_write_preamble();
        test_read();
        test_read_error();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
